// File: rtl/mem_lsu_if.sv
// ============================================================================
// Module      : mem_lsu_if
// Description : Bundles the EX-side op handshake, the memory request bus and
//               the WB-side result handshake of the load/store unit.
//               master = the load/store unit, slave = its environment.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mem_lsu_if #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 16,
  parameter int REG_AW = 5
) ();

  // upstream (EX) op
  logic              in_valid;
  logic              in_ready;
  logic [XLEN-1:0]   in_rd_data;
  logic              in_rd_en;
  logic [REG_AW-1:0] in_rd_addr;
  logic              in_load;
  logic              in_store;
  logic [2:0]        in_funct3;
  logic [XLEN-1:0]   in_store_data;

  // memory bus
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [XLEN/8-1:0] mem_be;
  logic [XLEN-1:0]   mem_wdata;
  logic              mem_gnt;
  logic              mem_rvalid;
  logic [XLEN-1:0]   mem_rdata;

  // downstream (WB) result
  logic              out_valid;
  logic              out_ready;
  logic [XLEN-1:0]   out_rd_data;
  logic              out_rd_en;
  logic [REG_AW-1:0] out_rd_addr;
  logic              out_misalign;

  modport master (
    input  in_valid, in_rd_data, in_rd_en, in_rd_addr, in_load, in_store,
           in_funct3, in_store_data,
    output in_ready,
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata,
    output out_valid, out_rd_data, out_rd_en, out_rd_addr, out_misalign,
    input  out_ready
  );

  modport slave (
    output in_valid, in_rd_data, in_rd_en, in_rd_addr, in_load, in_store,
           in_funct3, in_store_data,
    input  in_ready,
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_gnt, mem_rvalid, mem_rdata,
    input  out_valid, out_rd_data, out_rd_en, out_rd_addr, out_misalign,
    output out_ready
  );

endinterface

`default_nettype wire

// File: rtl/mem_lsu.sv
// ============================================================================
// Module      : mem_lsu
// Description : Single-outstanding load/store unit between EX and WB.
//               Captures one op, issues at most one memory request, aligns
//               and extends load data, and holds the result until WB takes it.
//               Optional macro LSU_MISALIGN_TRAP_EN: misaligned accesses are
//               flagged on out_misalign instead of being silently aligned.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_lsu #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 16,
  parameter int REG_AW = 5
) (
  input  logic      clk,
  input  logic      rst,
  mem_lsu_if.master bus
);

  localparam int c_BW   = XLEN / 8;
  localparam int c_OFFW = $clog2(c_BW);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_REQ  = 2'd1;
  localparam logic [1:0] c_WAIT = 2'd2;
  localparam logic [1:0] c_HOLD = 2'd3;

  localparam logic [c_BW-1:0] c_BE_B = c_BW'(1);
  localparam logic [c_BW-1:0] c_BE_H = c_BW'(3);
  localparam logic [c_BW-1:0] c_BE_W = c_BW'(15);
  localparam logic [c_BW-1:0] c_BE_D = '1;

  logic [1:0]        r_state;
  logic [1:0]        w_next;
  logic              w_in_ready;
  logic              w_accept;

  // decode of the op being offered
  logic              w_is_store;
  logic              w_is_mem;
  logic [1:0]        w_size;
  logic              w_supported;
  logic [c_OFFW-1:0] w_off;
  logic [c_OFFW-1:0] w_off_al;
  logic              w_trap;
  logic              w_go_req;
  logic [ADDR_W-1:0] w_addr_al;
  logic [c_BW-1:0]   w_be;
  logic [XLEN-1:0]   w_wdata;

  // captured op
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [c_BW-1:0]   r_be;
  logic [XLEN-1:0]   r_wdata;
  logic [2:0]        r_funct3;
  logic [c_OFFW-1:0] r_off;
  logic              r_rd_en;

  // result
  logic [XLEN-1:0]   r_out_rd_data;
  logic              r_out_rd_en;
  logic [REG_AW-1:0] r_out_rd_addr;
  logic              r_out_misalign;

  // load alignment
  logic [XLEN-1:0]   w_lane;
  logic [XLEN-1:0]   w_load_ext;

  assign w_in_ready = ((r_state == c_IDLE) || ((r_state == c_HOLD) && bus.out_ready)) && !rst;
  assign w_accept   = bus.in_valid && w_in_ready;

  // a store flag wins over a load flag
  assign w_is_store = bus.in_store;
  assign w_is_mem   = bus.in_store || bus.in_load;
  assign w_size     = bus.in_funct3[1:0];
  assign w_off      = bus.in_rd_data[c_OFFW-1:0];
  assign w_addr_al  = {bus.in_rd_data[ADDR_W-1:c_OFFW], {c_OFFW{1'b0}}};

  // classify funct3 as a legal size/sign code for this op kind
  always_comb begin
    w_supported = 1'b0;
    if (w_is_store) begin
      case (bus.in_funct3)
        3'b000, 3'b001, 3'b010: w_supported = 1'b1;
        3'b011:                 w_supported = (XLEN == 64);
        default:                w_supported = 1'b0;
      endcase
    end else begin
      case (bus.in_funct3)
        3'b000, 3'b001, 3'b010,
        3'b100, 3'b101, 3'b110: w_supported = 1'b1;
        3'b011:                 w_supported = (XLEN == 64);
        default:                w_supported = 1'b0;
      endcase
    end
  end

  // clear offset bits below the access size; a difference from w_off means misaligned
  always_comb begin
    w_off_al = w_off;
    case (w_size)
      2'd1:    w_off_al[0]   = 1'b0;
      2'd2:    w_off_al[1:0] = 2'b00;
      2'd3:    w_off_al      = '0;
      default: w_off_al      = w_off;
    endcase
  end

`ifdef LSU_MISALIGN_TRAP_EN
  assign w_trap = w_is_mem && w_supported && (w_off != w_off_al);
`else
  assign w_trap = 1'b0;
`endif

  assign w_go_req = w_is_mem && w_supported && !w_trap;

  // store byte enables and lane-replicated write data
  always_comb begin
    case (w_size)
      2'd0: begin
        w_be    = c_BE_B << w_off_al;
        w_wdata = {c_BW{bus.in_store_data[7:0]}};
      end
      2'd1: begin
        w_be    = c_BE_H << w_off_al;
        w_wdata = {(XLEN/16){bus.in_store_data[15:0]}};
      end
      2'd2: begin
        w_be    = c_BE_W << w_off_al;
        w_wdata = {(XLEN/32){bus.in_store_data[31:0]}};
      end
      default: begin
        w_be    = c_BE_D;
        w_wdata = bus.in_store_data;
      end
    endcase
  end

  // pick the addressed lane out of the returned word and extend it
  assign w_lane = bus.mem_rdata >> {r_off, 3'b000};

  always_comb begin
    case (r_funct3)
      3'b000:  w_load_ext = XLEN'($signed(w_lane[7:0]));
      3'b001:  w_load_ext = XLEN'($signed(w_lane[15:0]));
      3'b010:  w_load_ext = XLEN'($signed(w_lane[31:0]));
      3'b100:  w_load_ext = XLEN'(w_lane[7:0]);
      3'b101:  w_load_ext = XLEN'(w_lane[15:0]);
      3'b110:  w_load_ext = XLEN'(w_lane[31:0]);
      default: w_load_ext = w_lane;
    endcase
  end

  // state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= c_IDLE;
    else     r_state <= w_next;
  end

  // next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      c_IDLE: if (w_accept) w_next = w_go_req ? c_REQ : c_HOLD;
      c_REQ:  if (bus.mem_gnt) w_next = r_we ? c_HOLD : c_WAIT;
      c_WAIT: if (bus.mem_rvalid) w_next = c_HOLD;
      c_HOLD: begin
        if (bus.out_ready) begin
          if (w_accept) w_next = w_go_req ? c_REQ : c_HOLD;
          else          w_next = c_IDLE;
        end
      end
      default: w_next = c_IDLE;
    endcase
  end

  // capture accepted ops and load results; out_* only change while not in HOLD
  always_ff @(posedge clk) begin
    if (rst) begin
      r_we           <= 1'b0;
      r_addr         <= '0;
      r_be           <= '0;
      r_wdata        <= '0;
      r_funct3       <= 3'b000;
      r_off          <= '0;
      r_rd_en        <= 1'b0;
      r_out_rd_data  <= '0;
      r_out_rd_en    <= 1'b0;
      r_out_rd_addr  <= '0;
      r_out_misalign <= 1'b0;
    end else if (w_accept) begin
      r_we           <= w_is_store;
      r_addr         <= w_addr_al;
      r_be           <= w_be;
      r_wdata        <= w_wdata;
      r_funct3       <= bus.in_funct3;
      r_off          <= w_off_al;
      r_rd_en        <= bus.in_rd_en;
      r_out_rd_data  <= (!w_is_mem && bus.in_rd_en) ? bus.in_rd_data : '0;
      r_out_rd_en    <= bus.in_rd_en && !w_trap;
      r_out_rd_addr  <= bus.in_rd_addr;
      r_out_misalign <= w_trap;  // constant 0 when the trap is compiled out
    end else if ((r_state == c_WAIT) && bus.mem_rvalid) begin
      r_out_rd_data  <= r_rd_en ? w_load_ext : '0;
    end
  end

  // state-decoded outputs; the request bus is zero outside REQ
  always_comb begin
    bus.in_ready  = w_in_ready;
    bus.mem_req   = (r_state == c_REQ);
    bus.mem_we    = (r_state == c_REQ) && r_we;
    bus.mem_addr  = (r_state == c_REQ) ? r_addr  : '0;
    bus.mem_be    = (r_state == c_REQ) ? r_be    : '0;
    bus.mem_wdata = (r_state == c_REQ) ? r_wdata : '0;
    bus.out_valid = (r_state == c_HOLD);
  end

  assign bus.out_rd_data  = r_out_rd_data;
  assign bus.out_rd_en    = r_out_rd_en;
  assign bus.out_rd_addr  = r_out_rd_addr;
  assign bus.out_misalign = r_out_misalign;

endmodule

`default_nettype wire

// File: tb/tb_mem_lsu.sv
// ============================================================================
// Module      : tb_mem_lsu
// Description : Directed self-checking bench for mem_lsu (XLEN=32).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_lsu;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  mem_lsu_if #(.XLEN(32), .ADDR_W(16), .REG_AW(5)) bus ();

  mem_lsu #(.XLEN(32), .ADDR_W(16), .REG_AW(5)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // hard stop in case the sequence ever stalls
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout, expected end of sequence");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic ld, input logic st, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] sd,
                       input logic en, input logic [4:0] ra);
    bus.in_load       = ld;
    bus.in_store      = st;
    bus.in_funct3     = f3;
    bus.in_rd_data    = a;
    bus.in_store_data = sd;
    bus.in_rd_en      = en;
    bus.in_rd_addr    = ra;
    bus.in_valid      = 1'b1;
    step();
    bus.in_valid = 1'b0;
    bus.in_load  = 1'b0;
    bus.in_store = 1'b0;
  endtask

  task automatic grant();
    bus.mem_gnt = 1'b1;
    step();
    bus.mem_gnt = 1'b0;
  endtask

  task automatic respond(input logic [31:0] d);
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = d;
    step();
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = 32'h0;
  endtask

  task automatic retire(input string tag);
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    check(tag, {63'd0, bus.out_valid}, 64'd0);
  endtask

  // aligned-or-not load with an immediate grant; checks the returned value
  task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] rdata, input logic [31:0] exp);
    issue(1'b1, 1'b0, f3, a, 32'h0, 1'b1, 5'd5);
    check({tag, "_req"}, {63'd0, bus.mem_req}, 64'd1);
    check({tag, "_addr"}, {48'd0, bus.mem_addr}, {48'd0, a[15:2], 2'b00});
    grant();
    check({tag, "_wait"}, {62'd0, bus.mem_req, bus.out_valid}, 64'd0);
    respond(rdata);
    check({tag, "_valid"}, {63'd0, bus.out_valid}, 64'd1);
    check({tag, "_data"}, {32'd0, bus.out_rd_data}, {32'd0, exp});
    check({tag, "_rdaddr"}, {59'd0, bus.out_rd_addr}, 64'd5);
    retire({tag, "_retire"});
  endtask

  initial begin
    n_checks          = 0;
    n_fail            = 0;
    rst               = 1'b1;
    bus.in_valid      = 1'b0;
    bus.in_rd_data    = 32'h0;
    bus.in_rd_en      = 1'b0;
    bus.in_rd_addr    = 5'd0;
    bus.in_load       = 1'b0;
    bus.in_store      = 1'b0;
    bus.in_funct3     = 3'b000;
    bus.in_store_data = 32'h0;
    bus.mem_gnt       = 1'b0;
    bus.mem_rvalid    = 1'b0;
    bus.mem_rdata     = 32'h0;
    bus.out_ready     = 1'b0;

    // reset state
    step();
    step();
    check("rst_in_ready", {63'd0, bus.in_ready}, 64'd0);
    check("rst_ctl", {59'd0, bus.mem_req, bus.mem_we, bus.out_valid, bus.out_rd_en, bus.out_misalign}, 64'd0);
    check("rst_bus", {12'd0, bus.mem_addr, bus.mem_be, bus.mem_wdata}, 64'd0);
    check("rst_out", {27'd0, bus.out_rd_addr, bus.out_rd_data}, 64'd0);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", {63'd0, bus.in_ready}, 64'd1);

    // SW with the grant two cycles late
    issue(1'b0, 1'b1, 3'b010, 32'h0000_0104, 32'hDEAD_BEEF, 1'b0, 5'd0);
    check("sw_req_c1", {62'd0, bus.mem_req, bus.mem_we}, 64'd3);
    check("sw_addr", {48'd0, bus.mem_addr}, 64'h0104);
    check("sw_be", {60'd0, bus.mem_be}, 64'hF);
    check("sw_wdata", {32'd0, bus.mem_wdata}, 64'hDEAD_BEEF);
    step();
    check("sw_req_c2", {63'd0, bus.mem_req}, 64'd1);
    step();
    check("sw_req_c3", {31'd0, bus.mem_req, bus.mem_wdata}, {31'd0, 1'b1, 32'hDEAD_BEEF});
    grant();
    check("sw_done", {62'd0, bus.mem_req, bus.out_valid}, 64'd1);
    check("sw_rd", {31'd0, bus.out_rd_en, bus.out_rd_data}, 64'd0);
    retire("sw_retire");

    // byte loads at the top lane
    do_load("lb", 3'b000, 32'h0000_0103, 32'h80FF_0000, 32'hFFFF_FF80);
    do_load("lbu", 3'b100, 32'h0000_0103, 32'h80FF_0000, 32'h0000_0080);

    // halfword store / loads at the upper half
    issue(1'b0, 1'b1, 3'b001, 32'h0000_0102, 32'h1234_ABCD, 1'b0, 5'd0);
    check("sh_be", {60'd0, bus.mem_be}, 64'hC);
    check("sh_wdata", {32'd0, bus.mem_wdata}, 64'hABCD_ABCD);
    check("sh_addr", {48'd0, bus.mem_addr}, 64'h0100);
    grant();
    retire("sh_retire");
    do_load("lhu", 3'b101, 32'h0000_0102, 32'hABCD_0000, 32'h0000_ABCD);
    do_load("lh", 3'b001, 32'h0000_0102, 32'hABCD_0000, 32'hFFFF_ABCD);

    // byte store in lane 1
    issue(1'b0, 1'b1, 3'b000, 32'h0000_0101, 32'h0000_0077, 1'b0, 5'd0);
    check("sb_be", {60'd0, bus.mem_be}, 64'h2);
    check("sb_wdata", {32'd0, bus.mem_wdata}, 64'h7777_7777);
    grant();
    retire("sb_retire");

    // load and store both set: treated as a store
    issue(1'b1, 1'b1, 3'b010, 32'h0000_0200, 32'h0BAD_F00D, 1'b0, 5'd0);
    check("ldst_we", {62'd0, bus.mem_req, bus.mem_we}, 64'd3);
    grant();
    check("ldst_hold", {63'd0, bus.out_valid}, 64'd1);
    retire("ldst_retire");

    // non-memory op stalled by WB, then back-to-back accept
    issue(1'b0, 1'b0, 3'b000, 32'h0000_0055, 32'h0, 1'b1, 5'd7);
    for (int i = 0; i < 3; i++) begin
      check("nm_stall", {30'd0, bus.out_valid, bus.in_ready, bus.out_rd_data}, {30'd0, 2'b10, 32'h55});
      step();
    end
    bus.in_load    = 1'b0;
    bus.in_store   = 1'b0;
    bus.in_rd_data = 32'h0000_0066;
    bus.in_rd_en   = 1'b1;
    bus.in_rd_addr = 5'd8;
    bus.in_valid   = 1'b1;
    bus.out_ready  = 1'b1;
    #1;
    check("nm_b2b_ready", {63'd0, bus.in_ready}, 64'd1);
    step();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    check("nm_b2b_data", {26'd0, bus.out_valid, bus.out_rd_addr, bus.out_rd_data}, {26'd0, 1'b1, 5'd8, 32'h66});
    retire("nm_retire");

    // rd_en low forces zero data
    issue(1'b0, 1'b0, 3'b000, 32'h0000_1234, 32'h0, 1'b0, 5'd3);
    check("nm_noen", {31'd0, bus.out_rd_en, bus.out_rd_data}, 64'd0);
    retire("noen_retire");

    // unsupported funct3 (LD on XLEN=32): no access, zero data
    issue(1'b1, 1'b0, 3'b011, 32'h0000_0100, 32'h0, 1'b1, 5'd4);
    check("unsup", {29'd0, bus.mem_req, bus.out_valid, bus.out_rd_data}, {29'd0, 2'b01, 32'h0});
    retire("unsup_retire");

    // misaligned word load
`ifdef LSU_MISALIGN_TRAP_EN
    issue(1'b1, 1'b0, 3'b010, 32'h0000_0102, 32'h0, 1'b1, 5'd5);
    check("mis_trap_ctl", {60'd0, bus.mem_req, bus.out_valid, bus.out_misalign, bus.out_rd_en}, 64'h6);
    check("mis_trap_data", {32'd0, bus.out_rd_data}, 64'd0);
    retire("mis_retire");
`else
    do_load("mis_lw", 3'b010, 32'h0000_0102, 32'hCAFE_F00D, 32'hCAFE_F00D);
    issue(1'b0, 1'b1, 3'b001, 32'h0000_0103, 32'h0000_5AA5, 1'b0, 5'd0);
    check("mis_sh_be", {60'd0, bus.mem_be}, 64'hC);
    grant();
    check("mis_flag", {63'd0, bus.out_misalign}, 64'd0);
    retire("mis_sh_retire");
`endif

    // reset while waiting for read data; late rvalid is ignored
    issue(1'b1, 1'b0, 3'b010, 32'h0000_0200, 32'h0, 1'b1, 5'd9);
    grant();
    rst = 1'b1;
    step();
    check("wrst_ctl", {61'd0, bus.in_ready, bus.mem_req, bus.out_valid}, 64'd0);
    check("wrst_out", {26'd0, bus.out_rd_en, bus.out_rd_addr, bus.out_rd_data}, 64'd0);
    rst            = 1'b0;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'h0000_1111;
    #1;
    check("wrst_in_ready", {63'd0, bus.in_ready}, 64'd1);
    step();
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = 32'h0;
    check("wrst_ignored", {31'd0, bus.out_valid, bus.out_rd_data}, 64'd0);
    issue(1'b0, 1'b0, 3'b000, 32'h0000_0099, 32'h0, 1'b1, 5'd2);
    check("wrst_next", {31'd0, bus.out_valid, bus.out_rd_data}, {31'd0, 1'b1, 32'h99});
    retire("wrst_retire");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
